// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock divider generator: FSM encoding and minimum divide ratio.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV = 2;

endpackage : clk_gen_pkg

// File: rtl/clock_divider_gen.sv
// Programmable mclk divider producing a glitch-free registered bclk with phase offset,
// handshaked reconfiguration applied on period boundaries, and a rising-edge counter.
module clock_divider_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             bclk,
    output logic             rise_pulse,
    output logic             locked,
    output logic [CNT_W-1:0] edge_cnt
);

    state_e           r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_pcnt;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] r_pend_phase;
    logic             r_cfg_ready;
    logic             r_bclk;
    logic             r_rise;
    logic             r_locked;
    logic [CNT_W-1:0] r_edge_cnt;

    logic             w_accept;
    logic             w_boundary;
    logic             w_apply;
    logic             w_pend_stop;
    logic             w_start_run;
    logic [DIV_W-1:0] w_clamp_phase;
    logic [DIV_W-1:0] w_cnt_inc;
    logic [DIV_W-1:0] w_high;

    // A pending config exists exactly while cfg_ready is low.
    assign w_accept      = cfg_valid & r_cfg_ready;
    assign w_clamp_phase = (cfg_phase >= cfg_div) ? (cfg_div - DIV_W'(1)) : cfg_phase;
    assign w_boundary    = (r_state == ST_RUN) && (r_cnt == (r_div - DIV_W'(1)));
    assign w_apply       = ~r_cfg_ready && ((r_state != ST_RUN) || w_boundary);
    assign w_pend_stop   = (r_pend_div < DIV_W'(MIN_DIV));
    assign w_cnt_inc     = r_cnt + DIV_W'(1);
    assign w_high        = r_div - (r_div >> 1);

    // Every entry into cnt=0 of RUN follows a low cycle, so it is a bclk rising edge.
    assign w_start_run = (w_apply && !w_pend_stop && (r_pend_phase == '0))
                       || (!w_apply && (r_state == ST_PHASE) && (r_pcnt == DIV_W'(1)))
                       || (!w_apply && w_boundary);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_div        <= '0;
            r_cnt        <= '0;
            r_pcnt       <= '0;
            r_pend_div   <= '0;
            r_pend_phase <= '0;
            r_cfg_ready  <= 1'b1;
            r_bclk       <= 1'b0;
            r_rise       <= 1'b0;
            r_locked     <= 1'b0;
            r_edge_cnt   <= '0;
        end else begin
            r_rise <= w_start_run;
            if (w_start_run) begin
                r_edge_cnt <= r_edge_cnt + CNT_W'(1);
            end

            if (w_accept) begin
                r_pend_div   <= cfg_div;
                r_pend_phase <= w_clamp_phase;
                r_cfg_ready  <= 1'b0;
            end

            if (w_apply) begin
                r_cfg_ready <= 1'b1;
                r_div       <= r_pend_div;
                r_cnt       <= '0;
                if (w_pend_stop) begin
                    r_state  <= ST_IDLE;
                    r_bclk   <= 1'b0;
                    r_locked <= 1'b0;
                end else if (r_pend_phase == '0) begin
                    r_state  <= ST_RUN;
                    r_bclk   <= 1'b1;
                    r_locked <= 1'b1;
                end else begin
                    r_state  <= ST_PHASE;
                    r_pcnt   <= r_pend_phase;
                    r_bclk   <= 1'b0;
                    r_locked <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_bclk   <= 1'b0;
                        r_locked <= 1'b0;
                    end
                    ST_PHASE: begin
                        if (r_pcnt == DIV_W'(1)) begin
                            r_state  <= ST_RUN;
                            r_cnt    <= '0;
                            r_bclk   <= 1'b1;
                            r_locked <= 1'b1;
                        end else begin
                            r_pcnt <= r_pcnt - DIV_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (w_boundary) begin
                            r_cnt  <= '0;
                            r_bclk <= 1'b1;
                        end else begin
                            r_cnt  <= w_cnt_inc;
                            r_bclk <= (w_cnt_inc < w_high);
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_bclk   <= 1'b0;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cfg_ready  = r_cfg_ready;
    assign bclk       = r_bclk;
    assign rise_pulse = r_rise;
    assign locked     = r_locked;
    assign edge_cnt   = r_edge_cnt;

endmodule : clock_divider_gen

// File: tb/tb_clock_divider_gen.sv
// Bench for clock_divider_gen: directed scenarios plus randomized configs, all checked
// each cycle against a timeline model (bclk derived from the run start edge and N).
module tb_clock_divider_gen;

    localparam int unsigned DIV_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned LIMIT = 200;

    logic             mclk;
    logic             rst_n;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             bclk;
    logic             rise_pulse;
    logic             locked;
    logic [CNT_W-1:0] edge_cnt;

    clock_divider_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .cfg_div    (cfg_div),
        .cfg_phase  (cfg_phase),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .bclk       (bclk),
        .rise_pulse (rise_pulse),
        .locked     (locked),
        .edge_cnt   (edge_cnt)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_cmp = 0;
    int n_err = 0;

    // Timeline model: bclk is high when (edge - run_start) mod N < N - N/2.
    int               e = 0;
    int               m_run_start = -1;
    int               m_n = 2;
    int               m_pn = 0;
    int               m_pp = 0;
    bit               m_pending = 0;
    bit               m_acc = 0;
    logic [CNT_W-1:0] m_edges = '0;

    int   first_rise = -1;
    logic prev_b = 1'b0;
    time  t_prev = 0;
    time  t_last = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, e, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_run_start = -1;
        m_pending   = 0;
        m_acc       = 0;
        m_edges     = '0;
        prev_b      = 1'b0;
    endtask

    task automatic step();
        bit pend_prior;
        bit running_before;
        bit exp_b;
        bit exp_r;
        bit exp_l;
        int ph;
        @(posedge mclk);
        e++;
        pend_prior     = m_pending;
        running_before = (m_run_start >= 0) && (m_run_start <= e - 1);
        m_acc          = (cfg_valid === 1'b1) && !pend_prior;
        if (pend_prior && (!running_before || ((e - m_run_start) % m_n == 0))) begin
            m_pending = 0;
            if (m_pn < 2) begin
                m_run_start = -1;
            end else begin
                m_n         = m_pn;
                m_run_start = e + m_pp;
            end
        end
        if (m_acc) begin
            m_pending = 1;
            m_pn      = int'(cfg_div);
            m_pp      = (int'(cfg_phase) >= int'(cfg_div)) ? int'(cfg_div) - 1 : int'(cfg_phase);
        end
        exp_b = 0;
        exp_r = 0;
        exp_l = 0;
        if (m_run_start >= 0 && e >= m_run_start) begin
            ph    = (e - m_run_start) % m_n;
            exp_b = (ph < (m_n - m_n / 2));
            exp_r = (ph == 0);
            exp_l = 1;
        end
        if (exp_r) m_edges++;
        #1;
        chk("bclk", 32'(bclk), 32'(exp_b));
        chk("rise_pulse", 32'(rise_pulse), 32'(exp_r));
        chk("locked", 32'(locked), 32'(exp_l));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pending));
        chk("edge_cnt", 32'(edge_cnt), 32'(m_edges));
        if (bclk === 1'b1 && prev_b === 1'b0) begin
            if (first_rise < 0) first_rise = e;
            t_prev = t_last;
            t_last = $time;
        end
        prev_b = bclk;
    endtask

    // Holds cfg_valid until the request is taken; returns the accept edge.
    task automatic request(input int n, input int p, output int k);
        int guard;
        guard     = 0;
        cfg_div   = 8'(n);
        cfg_phase = 8'(p);
        cfg_valid = 1'b1;
        do begin
            step();
            guard++;
        end while (!m_acc && guard < LIMIT);
        chk("accept_in_time", 32'(m_acc), 32'd1);
        cfg_valid = 1'b0;
        k = e;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int k;
        int guard;
        rst_n     = 1'b0;
        cfg_div   = '0;
        cfg_phase = '0;
        cfg_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge mclk);
        #1;
        chk("rst_bclk", 32'(bclk), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        rst_n = 1'b1;
        run(5);

        // N=4, P=0 from idle
        first_rise = -1;
        request(4, 0, k);
        run(14);
        chk("n4_first_rise", 32'(first_rise), 32'(k + 1));
        chk("n4_period_ns", 32'(t_last - t_prev), 32'd40);

        // Reconfigure to N=6 mid-period
        run(1);
        request(6, 0, k);
        run(20);
        chk("n6_period_ns", 32'(t_last - t_prev), 32'd60);

        // Stop while running
        request(0, 0, k);
        run(15);
        chk("stop_bclk", 32'(bclk), 32'd0);
        chk("stop_locked", 32'(locked), 32'd0);
        chk("stop_frozen", 32'(edge_cnt), 32'(m_edges));

        // N=5, P=2 from idle
        first_rise = -1;
        request(5, 2, k);
        run(16);
        chk("n5p2_first_rise", 32'(first_rise), 32'(k + 3));
        chk("n5_period_ns", 32'(t_last - t_prev), 32'd50);
        request(0, 0, k);
        run(8);

        // N=3, P=7 clamps to P=2
        first_rise = -1;
        request(3, 7, k);
        run(10);
        chk("n3p7_first_rise", 32'(first_rise), 32'(k + 3));

        // Asynchronous reset while bclk is high
        guard = 0;
        while (bclk !== 1'b1 && guard < 10) begin
            step();
            guard++;
        end
        chk("bclk_high_before_rst", 32'(bclk), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_bclk", 32'(bclk), 32'd0);
        chk("async_rst_edge_cnt", 32'(edge_cnt), 32'd0);
        chk("async_rst_ready", 32'(cfg_ready), 32'd1);
        chk("async_rst_locked", 32'(locked), 32'd0);
        @(posedge mclk);
        e++;
        @(posedge mclk);
        e++;
        #1;
        rst_n = 1'b1;
        run(6);

        // N=2 long enough to wrap the edge counter
        request(2, 0, k);
        run(2 * (1 << CNT_W) + 10);
        request(0, 0, k);
        run(4);

        // Randomized configs, including stop requests and oversized phases
        for (int t = 0; t < 40; t++) begin
            request(int'($urandom_range(0, 9)), int'($urandom_range(0, 12)), k);
            run(int'($urandom_range(0, 25)));
        end
        request(0, 0, k);
        run(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_clock_divider_gen

// File: doc/clock_divider_gen.md
CLOCK_DIVIDER_GEN -- requirements
Module: clock_divider_gen

Interface
REQ-001 SHALL have parameter: DIV_W, 8, width of divide and phase fields.
REQ-002 SHALL have parameter: CNT_W, 16, width of the rising-edge counter.
REQ-003 SHALL have port: mclk  input  1  master clock; all logic is on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: cfg_div  input  DIV_W  requested divide ratio N.
REQ-006 SHALL have port: cfg_phase  input  DIV_W  requested phase offset P, in mclk cycles.
REQ-007 SHALL have port: cfg_valid  input  1  config request; held until accepted.
REQ-008 SHALL have port: cfg_ready  output  1  config can be accepted this cycle.
REQ-009 SHALL have port: bclk  output  1  generated clock, registered, glitch-free.
REQ-010 SHALL have port: rise_pulse  output  1  one-mclk pulse in each cycle where bclk goes 0->1.
REQ-011 SHALL have port: locked  output  1  high while in RUN.
REQ-012 SHALL have port: edge_cnt  output  CNT_W  count of bclk rising edges, wraps to 0.

Function
REQ-013 SHALL implement states IDLE (bclk=0), PHASE (bclk=0, counting P down), RUN (dividing).
REQ-014 SHALL accept a config on any mclk edge with cfg_valid=1 and cfg_ready=1; cfg_valid while cfg_ready=0 is ignored.
REQ-015 SHALL clamp P to N-1 when P>=N.
REQ-016 SHALL treat N<2 as a stop request: go to IDLE with bclk=0 at the apply point.
REQ-017 SHALL apply accepted configs immediately in IDLE or PHASE, and in RUN only at the period boundary (the edge ending the cycle with cnt=N-1).
REQ-018 SHALL keep cfg_ready=0 from the accept edge until the apply edge, then cfg_ready=1 from the next cycle.
REQ-019 SHALL, at apply with N>=2 and P=0, enter RUN with cnt=0 and bclk=1 on that edge.
REQ-020 SHALL, at apply with P>0, enter PHASE and hold bclk=0 for P cycles, then enter RUN with cnt=0 and bclk=1.
REQ-021 SHALL therefore make the first rising edge appear at accept edge k+1+P when accepted from IDLE.
REQ-022 SHALL in RUN drive bclk high for H=N-floor(N/2) cycles and low for floor(N/2) cycles, giving period N (odd N: high phase one cycle longer).
REQ-023 SHALL wrap cnt from N-1 to 0, with bclk=1 on the wrap edge.
REQ-024 SHALL assert rise_pulse in exactly the cycles where bclk goes 0->1, and increment edge_cnt on the same edge.
REQ-025 SHALL wrap edge_cnt from 2^CNT_W-1 to 0.
REQ-026 SHALL change bclk at most once per mclk cycle, with no intermediate period shorter than min(old N, new N) at reconfiguration.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronously, including mid-period), force state=IDLE, bclk=0, rise_pulse=0, locked=0, edge_cnt=0, cnt=0, pending config cleared, and cfg_ready=1.
REQ-028 SHALL start operation only after a config is accepted following reset release.

Structure
REQ-029 SHALL place the state encoding (IDLE/PHASE/RUN) and MIN_DIV=2 in shared package clk_gen_pkg.
REQ-030 SHALL be a single module with no sub-modules; the counter, FSM, and config register SHALL all be inline.

Verification
REQ-031 SHALL verify: N=4, P=0 accepted at edge k -> bclk rises at edges k+1, k+5, k+9, high 2 / low 2 cycles, and the bench measures bclk period=4*mclk.
REQ-032 SHALL verify: N=5, P=2 -> first rise at k+3, then high 3 / low 2, period 5, locked=1 from k+3.
REQ-033 SHALL verify: reconfig from N=4 to N=6 mid-period -> cfg_ready=0 until the boundary, the old period completes, and the next periods are 6 with no short pulse.
REQ-034 SHALL verify: N=0 while running -> bclk stays 0 after the current period ends, locked=0, and edge_cnt is frozen.
REQ-035 SHALL verify: N=3, P=7 -> P is clamped to 2, and the first rise occurs at k+3.
REQ-036 SHALL verify: rst_n pulled low while bclk=1 -> bclk=0 immediately (before the next mclk edge), and edge_cnt=0.
